// File: rtl/extrema_pkg.sv
// Shared helpers for the windowed extrema tracker: counter width derivation and
// a sign-selectable greater-than built on a (W+1)-bit subtraction.
package extrema_pkg;

    // Widest sample supported by the compare helper.
    localparam int MAX_W = 32;
    localparam int EXT_W = MAX_W + 1;

    function automatic int cnt_w(input int win_len);
        return (win_len > 1) ? $clog2(win_len) : 1;
    endfunction

    // Operands arrive already extended to w+1 bits and zero-padded to EXT_W.
    // Bit w of (b - a) is the sign of the (w+1)-bit difference, so it is set
    // exactly when a > b; the padding never disturbs the low w+1 bits.
    function automatic logic gt_ext(input logic [EXT_W-1:0] a_x,
                                    input logic [EXT_W-1:0] b_x,
                                    input int               w);
        logic [EXT_W-1:0] diff;
        diff = (b_x - a_x) >> w;
        return diff[0];
    endfunction

endpackage

// File: rtl/window_extrema_if.sv
// Sample stream in, running and per-window extrema out, for window_extrema.
interface window_extrema_if #(parameter int DATA_W = 9);

    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              clear;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min;
    logic              run_valid;
    logic [DATA_W-1:0] win_max;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_p2p;
    logic              win_valid;

    modport master (
        output in_valid, data_in, clear,
        input  run_max, run_min, run_valid, win_max, win_min, win_p2p, win_valid
    );

    modport slave (
        input  in_valid, data_in, clear,
        output run_max, run_min, run_valid, win_max, win_min, win_p2p, win_valid
    );

endinterface

// File: rtl/extrema_cmp.sv
// Combinational strict a > b on DATA_W-bit samples, signed or unsigned.
// No latency, no flow control.
module extrema_cmp
    import extrema_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_gt_b
);

    logic [DATA_W:0] a_x;
    logic [DATA_W:0] b_x;

    assign a_x    = {(SIGNED ? a[DATA_W-1] : 1'b0), a};
    assign b_x    = {(SIGNED ? b[DATA_W-1] : 1'b0), b};
    assign a_gt_b = gt_ext(EXT_W'(a_x), EXT_W'(b_x), DATA_W);

endmodule

// File: rtl/window_extrema.sv
// Windowed min/max tracker: sample -> run_* in 2 edges, closing sample -> win_* in 2 edges.
// No backpressure: one sample per clock is always accepted, across window boundaries too.
module window_extrema
    import extrema_pkg::*;
#(
    parameter int DATA_W  = 9,
    parameter int WIN_LEN = 1024,
    parameter bit SIGNED  = 1'b0
) (
    input logic              clock,
    input logic              rst,
    window_extrema_if.slave  bus
);

    localparam int                CNT_W = cnt_w(WIN_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN_LEN - 1);

    logic [DATA_W-1:0] s1_data;
    logic              s1_vld;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min;
    logic              run_valid;
    logic [DATA_W-1:0] win_max;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_p2p;
    logic              win_valid;

    logic              new_gt_max;
    logic              new_lt_min;
    logic [DATA_W-1:0] next_max;
    logic [DATA_W-1:0] next_min;
    logic              closing;

    extrema_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_max (
        .a      (s1_data),
        .b      (run_max),
        .a_gt_b (new_gt_max)
    );

    // Operands swapped: run_min > s1_data means the new sample is a new minimum.
    extrema_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_min (
        .a      (run_min),
        .b      (s1_data),
        .a_gt_b (new_lt_min)
    );

    assign next_max = (!run_valid || new_gt_max) ? s1_data : run_max;
    assign next_min = (!run_valid || new_lt_min) ? s1_data : run_min;
    assign closing  = s1_vld && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_data   <= '0;
            s1_vld    <= 1'b0;
            cnt       <= '0;
            run_max   <= '0;
            run_min   <= '0;
            run_valid <= 1'b0;
            win_max   <= '0;
            win_min   <= '0;
            win_p2p   <= '0;
            win_valid <= 1'b0;
        end else if (bus.clear) begin
            s1_vld    <= 1'b0;
            cnt       <= '0;
            run_valid <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            s1_vld    <= bus.in_valid;
            win_valid <= closing;
            if (bus.in_valid) begin
                s1_data <= bus.data_in;
            end
            if (s1_vld) begin
                run_max <= next_max;
                run_min <= next_min;
                if (closing) begin
                    win_max   <= next_max;
                    win_min   <= next_min;
                    win_p2p   <= next_max - next_min;
                    cnt       <= '0;
                    run_valid <= 1'b0;
                end else begin
                    cnt       <= cnt + 1'b1;
                    run_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.run_max   = run_max;
    assign bus.run_min   = run_min;
    assign bus.run_valid = run_valid;
    assign bus.win_max   = win_max;
    assign bus.win_min   = win_min;
    assign bus.win_p2p   = win_p2p;
    assign bus.win_valid = win_valid;

endmodule

// File: tb/tb_window_extrema.sv
// Directed bench for window_extrema: unsigned/signed 4-sample windows, gaps,
// clear, single-sample windows and reset during a window close.
module tb_window_extrema;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    window_extrema_if #(.DATA_W(9)) if_u ();
    window_extrema_if #(.DATA_W(9)) if_s ();
    window_extrema_if #(.DATA_W(9)) if_1 ();

    window_extrema #(.DATA_W(9), .WIN_LEN(4), .SIGNED(1'b0)) dut_u (
        .clock (clk), .rst (rst), .bus (if_u.slave));
    window_extrema #(.DATA_W(9), .WIN_LEN(4), .SIGNED(1'b1)) dut_s (
        .clock (clk), .rst (rst), .bus (if_s.slave));
    window_extrema #(.DATA_W(9), .WIN_LEN(1), .SIGNED(1'b0)) dut_1 (
        .clock (clk), .rst (rst), .bus (if_1.slave));

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if ({if_u.run_max, if_u.run_min, if_u.run_valid, if_u.win_max, if_u.win_min,
             if_u.win_p2p, if_u.win_valid} !== 47'd0) begin
            errors++;
            $display("FAIL reset_u: outputs %h, want 0", {if_u.run_max, if_u.run_min,
                     if_u.run_valid, if_u.win_max, if_u.win_min, if_u.win_p2p, if_u.win_valid});
        end
        checks++;
        if ({if_s.run_max, if_s.run_min, if_s.run_valid, if_s.win_max, if_s.win_min,
             if_s.win_p2p, if_s.win_valid} !== 47'd0) begin
            errors++;
            $display("FAIL reset_s: outputs nonzero");
        end
        checks++;
        if ({if_1.run_max, if_1.run_min, if_1.run_valid, if_1.win_max, if_1.win_min,
             if_1.win_p2p, if_1.win_valid} !== 47'd0) begin
            errors++;
            $display("FAIL reset_1: outputs nonzero");
        end
        rst = 1'b0;
        step();
        checks++;
        if ({if_u.run_valid, if_u.win_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: run_valid/win_valid %b, want 00",
                     {if_u.run_valid, if_u.win_valid});
        end
    endtask

    task automatic test_unsigned();
        logic [8:0] v [4];
        v = '{9'd5, 9'd200, 9'd3, 9'd100};
        for (int i = 0; i < 4; i++) begin
            if_u.in_valid = 1'b1;
            if_u.data_in  = v[i];
            step();
            if (i == 0) begin
                checks++;
                if (if_u.run_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL uns_latency: run_valid %b after 1 edge, want 0", if_u.run_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if ({if_u.run_max, if_u.run_min, if_u.run_valid} !== {9'd5, 9'd5, 1'b1}) begin
                    errors++;
                    $display("FAIL uns_first: max %0d min %0d vld %b, want 5 5 1",
                             if_u.run_max, if_u.run_min, if_u.run_valid);
                end
            end
            if (i == 3) begin
                checks++;
                if ({if_u.run_max, if_u.run_min, if_u.win_valid} !== {9'd200, 9'd3, 1'b0}) begin
                    errors++;
                    $display("FAIL uns_running: max %0d min %0d wv %b, want 200 3 0",
                             if_u.run_max, if_u.run_min, if_u.win_valid);
                end
            end
        end
        if_u.in_valid = 1'b0;
        step();
        checks++;
        if (if_u.win_valid !== 1'b1) begin
            errors++;
            $display("FAIL uns_win_valid: got %b, want 1", if_u.win_valid);
        end
        checks++;
        if ({if_u.win_max, if_u.win_min, if_u.win_p2p} !== {9'd200, 9'd3, 9'd197}) begin
            errors++;
            $display("FAIL uns_window: max %0d min %0d p2p %0d, want 200 3 197",
                     if_u.win_max, if_u.win_min, if_u.win_p2p);
        end
        checks++;
        if (if_u.run_valid !== 1'b0) begin
            errors++;
            $display("FAIL uns_run_valid_close: got %b, want 0", if_u.run_valid);
        end
        step();
        checks++;
        if ({if_u.win_valid, if_u.win_max} !== {1'b0, 9'd200}) begin
            errors++;
            $display("FAIL uns_pulse_end: wv %b max %0d, want 0 200", if_u.win_valid, if_u.win_max);
        end
    endtask

    task automatic test_signed();
        logic [8:0] v [4];
        v = '{9'h100, 9'h0FF, 9'h1FF, 9'h000};
        for (int i = 0; i < 4; i++) begin
            if_s.in_valid = 1'b1;
            if_s.data_in  = v[i];
            step();
        end
        checks++;
        if ({if_s.run_max, if_s.run_min} !== {9'h0FF, 9'h100}) begin
            errors++;
            $display("FAIL sgn_running: max %h min %h, want 0ff 100", if_s.run_max, if_s.run_min);
        end
        if_s.in_valid = 1'b0;
        step();
        checks++;
        if (if_s.win_valid !== 1'b1) begin
            errors++;
            $display("FAIL sgn_win_valid: got %b, want 1", if_s.win_valid);
        end
        checks++;
        if ({if_s.win_max, if_s.win_min, if_s.win_p2p} !== {9'h0FF, 9'h100, 9'h1FF}) begin
            errors++;
            $display("FAIL sgn_window: max %h min %h p2p %h, want 0ff 100 1ff",
                     if_s.win_max, if_s.win_min, if_s.win_p2p);
        end
    endtask

    task automatic test_gapped();
        int npulse;
        int p0;
        int p1;
        logic [8:0] v [8];
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            if_u.in_valid = (i % 2 == 0) && (i < 8);
            if_u.data_in  = 9'(10 * (i / 2 + 1));
            step();
            if (if_u.win_valid === 1'b1) begin
                npulse++;
                checks++;
                if ({if_u.win_max, if_u.win_min, if_u.win_p2p} !== {9'd40, 9'd10, 9'd30}) begin
                    errors++;
                    $display("FAIL gap_window: max %0d min %0d p2p %0d, want 40 10 30",
                             if_u.win_max, if_u.win_min, if_u.win_p2p);
                end
            end
        end
        checks++;
        if (npulse !== 1) begin
            errors++;
            $display("FAIL gap_pulses: got %0d pulses, want 1", npulse);
        end

        v = '{9'd50, 9'd60, 9'd55, 9'd52, 9'd100, 9'd110, 9'd105, 9'd101};
        npulse = 0;
        p0 = -1;
        p1 = -1;
        for (int i = 0; i < 12; i++) begin
            if_u.in_valid = (i < 8);
            if_u.data_in  = v[i % 8];
            step();
            if (if_u.win_valid === 1'b1) begin
                if (npulse == 0) begin
                    p0 = i;
                    checks++;
                    if ({if_u.win_max, if_u.win_min, if_u.win_p2p} !== {9'd60, 9'd50, 9'd10}) begin
                        errors++;
                        $display("FAIL b2b_win_a: max %0d min %0d p2p %0d, want 60 50 10",
                                 if_u.win_max, if_u.win_min, if_u.win_p2p);
                    end
                end else begin
                    p1 = i;
                    checks++;
                    if ({if_u.win_max, if_u.win_min, if_u.win_p2p} !== {9'd110, 9'd100, 9'd10}) begin
                        errors++;
                        $display("FAIL b2b_win_b: max %0d min %0d p2p %0d, want 110 100 10",
                                 if_u.win_max, if_u.win_min, if_u.win_p2p);
                    end
                end
                npulse++;
            end
        end
        checks++;
        if (npulse !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses, want 2", npulse);
        end
        checks++;
        if (p1 - p0 !== 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, want 4", p1 - p0);
        end
    endtask

    task automatic test_clear();
        int npulse;
        logic [8:0] v [4];
        npulse = 0;
        if_u.in_valid = 1'b1;
        if_u.data_in  = 9'd7;
        step();
        if (if_u.win_valid === 1'b1) npulse++;
        if_u.data_in = 9'd8;
        step();
        if (if_u.win_valid === 1'b1) npulse++;
        if_u.clear   = 1'b1;
        if_u.data_in = 9'd250;
        step();
        if (if_u.win_valid === 1'b1) npulse++;
        checks++;
        if ({if_u.run_valid, if_u.win_valid} !== 2'b00) begin
            errors++;
            $display("FAIL clr_state: run_valid/win_valid %b, want 00",
                     {if_u.run_valid, if_u.win_valid});
        end
        checks++;
        if ({if_u.win_max, if_u.win_min, if_u.win_p2p} !== {9'd110, 9'd100, 9'd10}) begin
            errors++;
            $display("FAIL clr_hold: max %0d min %0d p2p %0d, want 110 100 10",
                     if_u.win_max, if_u.win_min, if_u.win_p2p);
        end
        if_u.clear = 1'b0;
        v = '{9'd20, 9'd30, 9'd40, 9'd35};
        for (int i = 0; i < 8; i++) begin
            if_u.in_valid = (i < 4);
            if_u.data_in  = v[i % 4];
            step();
            if (if_u.win_valid === 1'b1) begin
                npulse++;
                checks++;
                if ({if_u.win_max, if_u.win_min, if_u.win_p2p} !== {9'd40, 9'd20, 9'd20}) begin
                    errors++;
                    $display("FAIL clr_window: max %0d min %0d p2p %0d, want 40 20 20",
                             if_u.win_max, if_u.win_min, if_u.win_p2p);
                end
            end
        end
        checks++;
        if (npulse !== 1) begin
            errors++;
            $display("FAIL clr_pulses: got %0d pulses, want 1", npulse);
        end
    endtask

    task automatic test_win_len1();
        if_1.in_valid = 1'b1;
        if_1.data_in  = 9'd7;
        step();
        checks++;
        if (if_1.win_valid !== 1'b0) begin
            errors++;
            $display("FAIL len1_early: win_valid %b, want 0", if_1.win_valid);
        end
        if_1.data_in = 9'd9;
        step();
        checks++;
        if ({if_1.win_valid, if_1.win_max, if_1.win_min, if_1.win_p2p} !==
            {1'b1, 9'd7, 9'd7, 9'd0}) begin
            errors++;
            $display("FAIL len1_first: wv %b max %0d min %0d p2p %0d, want 1 7 7 0",
                     if_1.win_valid, if_1.win_max, if_1.win_min, if_1.win_p2p);
        end
        if_1.in_valid = 1'b0;
        step();
        checks++;
        if ({if_1.win_valid, if_1.win_max, if_1.win_min, if_1.win_p2p} !==
            {1'b1, 9'd9, 9'd9, 9'd0}) begin
            errors++;
            $display("FAIL len1_second: wv %b max %0d min %0d p2p %0d, want 1 9 9 0",
                     if_1.win_valid, if_1.win_max, if_1.win_min, if_1.win_p2p);
        end
        step();
        checks++;
        if (if_1.win_valid !== 1'b0) begin
            errors++;
            $display("FAIL len1_end: win_valid %b, want 0", if_1.win_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            if_u.in_valid = 1'b1;
            if_u.data_in  = 9'(i + 1);
            step();
        end
        if_u.in_valid = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({if_u.run_max, if_u.run_min, if_u.run_valid, if_u.win_max, if_u.win_min,
             if_u.win_p2p, if_u.win_valid} !== 47'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: outputs %h, want 0", {if_u.run_max, if_u.run_min,
                     if_u.run_valid, if_u.win_max, if_u.win_min, if_u.win_p2p, if_u.win_valid});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({if_u.win_valid, if_u.run_valid, if_u.win_max} !== {1'b0, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL rstmid_after: wv %b rv %b max %0d, want 0 0 0",
                     if_u.win_valid, if_u.run_valid, if_u.win_max);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_u.in_valid = 1'b0; if_u.data_in = '0; if_u.clear = 1'b0;
        if_s.in_valid = 1'b0; if_s.data_in = '0; if_s.clear = 1'b0;
        if_1.in_valid = 1'b0; if_1.data_in = '0; if_1.clear = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_gapped();
        test_clear();
        test_win_len1();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
